// File: rtl/storage_pkg.sv
// Shared types and constants for the storage access arbiter.
package storage_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Field order matches the {w1, r1, w0, r0} layout of the config bus.
    typedef struct packed {
        logic w1;
        logic r1;
        logic w0;
        logic r0;
    } perm_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Pick the permission bit that governs this requester/direction.
    function automatic logic perm_allows(input perm_t p, input logic req, input logic wr);
        logic ok;
        case ({req, wr})
            2'b00:   ok = p.r0;
            2'b01:   ok = p.w0;
            2'b10:   ok = p.r1;
            default: ok = p.w1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/storage_perm_table.sv
// Per-address permission register file with privileged, lockable writes.
module storage_perm_table
    import storage_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    input  logic              cfg_priv,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  perm_t             cfg_perm,
    input  logic              cfg_lock,
    input  logic [ADDR_W-1:0] lookup_addr,
    output perm_t             lookup_perm,
    output logic              cfg_err,
    output logic              locked
);

    perm_t perm_reg [DEPTH];
    logic  locked_reg;
    logic  cfg_err_reg;
    logic  cfg_accept;

    assign cfg_accept  = cfg_valid && cfg_priv && !locked_reg;
    // Combinational lookup: a write this cycle only shows from the next cycle.
    assign lookup_perm = perm_reg[lookup_addr];
    assign cfg_err     = cfg_err_reg;
    assign locked      = locked_reg;

    // Table, sticky lock and reject pulse; deny-all and unlocked out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                perm_reg[i] <= '0;
            end
            locked_reg  <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_valid && !cfg_accept;
            if (cfg_accept) begin
                perm_reg[cfg_addr] <= cfg_perm;
                if (cfg_lock) begin
                    locked_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/storage_access_arbiter.sv
// Round-robin, permission-checked access from two requesters to one storage port.
// Every transaction takes exactly four cycles, allowed or denied.
module storage_access_arbiter
    import storage_pkg::*;
#(
    parameter int ADDR_W  = storage_pkg::ADDR_W,
    parameter int DATA_W  = storage_pkg::DATA_W,
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    input  logic                      cfg_valid,
    input  logic                      cfg_priv,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [3:0]                cfg_perm,
    input  logic                      cfg_lock,
    output logic                      cfg_err,
    output logic                      locked,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    state_t            state_reg, state_next;
    logic              last_reg;
    logic              gnt_reg;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;
    logic [DATA_W-1:0] data_reg;

    logic              grant_valid;
    logic              grant_idx;
    logic              allowed;
    perm_t             lookup_perm;

    storage_perm_table u_perm_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_priv    (cfg_priv),
        .cfg_addr    (cfg_addr),
        .cfg_perm    (perm_t'(cfg_perm)),
        .cfg_lock    (cfg_lock),
        .lookup_addr (addr_reg),
        .lookup_perm (lookup_perm),
        .cfg_err     (cfg_err),
        .locked      (locked)
    );

    // Gating with reset_n keeps req_ready low while reset is held.
    assign grant_valid = (|req_valid) && reset_n;
    // Both valid: take the one not served last; otherwise the sole valid one.
    assign grant_idx   = (req_valid == 2'b11) ? ~last_reg : req_valid[1];
    assign allowed     = perm_allows(lookup_perm, gnt_reg, write_reg);

    // State register plus transaction latch, verdict and read-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            gnt_reg   <= 1'b0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        gnt_reg   <= grant_idx;
                        last_reg  <= grant_idx;
                        write_reg <= req_write[grant_idx];
                        addr_reg  <= grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        wdata_reg <= grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        err_reg   <= 1'b0;
                        data_reg  <= '0;
                    end
                end
                ISSUE: err_reg <= !allowed;
                WAIT: begin
                    if (!err_reg && !write_reg) begin
                        data_reg <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and all state-decoded outputs; everything idles at zero.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    req_ready  = grant_idx ? 2'b10 : 2'b01;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (allowed) begin
                    mem_en    = 1'b1;
                    mem_we    = write_reg;
                    mem_addr  = addr_reg;
                    mem_wdata = wdata_reg;
                end
                state_next = WAIT;
            end
            WAIT: state_next = RESP;
            RESP: begin
                rsp_valid  = gnt_reg ? 2'b10 : 2'b01;
                rsp_err    = err_reg;
                rsp_rdata  = data_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Directed self-checking bench for storage_access_arbiter with a storage model.
module tb_storage_access_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        cfg_valid;
    logic        cfg_priv;
    logic [3:0]  cfg_addr;
    logic [3:0]  cfg_perm;
    logic        cfg_lock;
    logic        cfg_err;
    logic        locked;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    // Storage model preloaded with 0x10 + address.
    logic [7:0] mem_model [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                                   8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    storage_access_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .cfg_valid (cfg_valid),
        .cfg_priv  (cfg_priv),
        .cfg_addr  (cfg_addr),
        .cfg_perm  (cfg_perm),
        .cfg_lock  (cfg_lock),
        .cfg_err   (cfg_err),
        .locked    (locked),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [35:0] all_outputs();
        return {req_ready, rsp_valid, rsp_rdata, rsp_err, cfg_err, locked,
                mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        cfg_valid = 1'b0;
        cfg_priv  = 1'b0;
        cfg_addr  = '0;
        cfg_perm  = '0;
        cfg_lock  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One request, followed cycle by cycle through ISSUE, WAIT and RESP.
    task automatic txn(input int r, input bit wr, input logic [3:0] a, input logic [7:0] d,
                       input bit exp_err, input logic [7:0] exp_rdata, input string name);
        int n = 0;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*4 +: 4]  = a;
        req_wdata[r*8 +: 8] = d;
        @(negedge clk);
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready[r]) begin
            errors++;
            $display("FAIL %s_grant: req_ready=%b, wanted bit %0d within 20 cycles", name, req_ready, r);
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we} !== {!exp_err, wr && !exp_err}) begin
            errors++;
            $display("FAIL %s_issue: en/we=%b%b, wanted %b%b", name, mem_en, mem_we, !exp_err, wr && !exp_err);
        end
        if (!exp_err) begin
            checks++;
            if (mem_addr !== a || (wr && mem_wdata !== d)) begin
                errors++;
                $display("FAIL %s_issue_bus: addr=%h wdata=%h, wanted addr=%h wdata=%h", name, mem_addr, mem_wdata, a, d);
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_wait: en/we/rsp=%b%b%b, wanted 0000", name, mem_en, mem_we, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== (r == 1 ? 2'b10 : 2'b01) || rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s_resp: valid=%b err=%b rdata=%h, wanted valid=%0d err=%b rdata=%h",
                     name, rsp_valid, rsp_err, rsp_rdata, r, exp_err, exp_rdata);
        end
        $display("txn %s: req=%0d wr=%0d addr=%h err=%b rdata=%h", name, r, wr, a, rsp_err, rsp_rdata);
    endtask

    task automatic cfg_write(input bit priv, input logic [3:0] a, input logic [3:0] p,
                             input bit lock, input bit exp_err, input string name);
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_priv  = priv;
        cfg_addr  = a;
        cfg_perm  = p;
        cfg_lock  = lock;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_lock  = 1'b0;
        checks++;
        if (cfg_err !== exp_err) begin
            errors++;
            $display("FAIL %s_cfg_err: cfg_err=%b, wanted %b", name, cfg_err, exp_err);
        end
        $display("cfg %s: priv=%0d addr=%h perm=%b lock=%0d cfg_err=%b", name, priv, a, p, lock, cfg_err);
    endtask

    task automatic test_reset();
        apply_reset();
        reset_n   = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (all_outputs() !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: outputs=%h, wanted 0", all_outputs());
        end
        req_valid = 2'b00;
        reset_n   = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outputs() !== 36'd0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%h, wanted 0", all_outputs());
        end
    endtask

    task automatic test_deny_default();
        txn(0, 1'b0, 4'd3, 8'h00, 1'b1, 8'h00, "deny_default");
    endtask

    task automatic test_write_read();
        cfg_write(1'b1, 4'd3, 4'b0011, 1'b0, 1'b0, "allow3");
        txn(0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h00, "write3");
        txn(0, 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, "read3");
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ready;
        logic [1:0] exp_rsp;
        apply_reset();
        cfg_write(1'b1, 4'd4, 4'b1111, 1'b0, 1'b0, "allow4");
        req_write = 2'b00;
        req_addr  = {4'd4, 4'd4};
        req_valid = 2'b11;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_ready = (c % 4 == 0) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp   = (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if (req_ready !== exp_ready || rsp_valid !== exp_rsp ||
                (exp_rsp != 2'b00 && rsp_rdata !== 8'h14)) begin
                errors++;
                $display("FAIL rr_cycle%0d: ready=%b rsp=%b rdata=%h, wanted ready=%b rsp=%b rdata=14",
                         c, req_ready, rsp_valid, rsp_rdata, exp_ready, exp_rsp);
            end
            if (exp_rsp != 2'b00)
                $display("txn rr%0d: req=%b rsp=%b rdata=%h", c / 4, exp_rsp, rsp_valid, rsp_rdata);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_unpriv_cfg();
        cfg_write(1'b0, 4'd5, 4'b1111, 1'b0, 1'b1, "unpriv5");
        txn(1, 1'b1, 4'd5, 8'h5A, 1'b1, 8'h00, "write5_denied");
    endtask

    task automatic test_lock();
        cfg_write(1'b1, 4'd7, 4'b1111, 1'b1, 1'b0, "lock7");
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_set: locked=%b, wanted 1", locked);
        end
        cfg_write(1'b1, 4'd7, 4'b0000, 1'b0, 1'b1, "locked7");
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_sticky: locked=%b, wanted 1", locked);
        end
        txn(1, 1'b0, 4'd7, 8'h00, 1'b0, 8'h17, "read7");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[7:4] = 4'd7;
        @(negedge clk);
        while (!req_ready[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready[1]) begin
            errors++;
            $display("FAIL mid_grant: req_ready=%b, wanted 10", req_ready);
        end
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n   = 1'b0;
        req_valid = 2'b01;
        #1;
        checks++;
        if (all_outputs() !== 36'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: outputs=%h, wanted 0", all_outputs());
        end
        @(negedge clk);
        req_valid = 2'b00;
        reset_n   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00 || locked !== 1'b0 || mem_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_after%0d: rsp=%b locked=%b mem_en=%b, wanted 0 0 0", c, rsp_valid, locked, mem_en);
            end
        end
        txn(1, 1'b0, 4'd7, 8'h00, 1'b1, 8'h00, "read7_after_reset");
        cfg_write(1'b1, 4'd7, 4'b1111, 1'b0, 1'b0, "unlocked7");
    endtask

    initial begin
        test_reset();
        test_deny_default();
        test_write_read();
        test_back_to_back();
        test_unpriv_cfg();
        test_lock();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
